sbox_1xn_buf: RTL

- Parametrised, buffered 1-to-N switch box for merged dataflow networks.
- Routes one FIFO-style input channel to one of NOUT output channels through a DEPTH-entry elastic buffer.
- Changes the selection safely: it drains in-flight tokens to the old destination before retargeting.
- Successor to the combinational 1x2 sbox. Used where the platform composer needs wider fan-out, registered timing and runtime reconfiguration.

---
 rtl/sbox_pkg.sv | 18 +
 rtl/sbox_elastic_buf.sv | 74 +++++++
 rtl/sbox_1xn_buf.sv | 112 +++++++++++
 3 files changed

// File: rtl/sbox_pkg.sv
// Shared types and sizing helpers for the buffered 1xN switch box.
package sbox_pkg;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DRAIN  = 2'd1,
      SWITCH = 2'd2
   } state_e;

   function automatic int unsigned f_selw(input int unsigned nout);
      return (nout < 2) ? 1 : $clog2(nout);
   endfunction

   function automatic int unsigned f_cntw(input int unsigned depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/sbox_elastic_buf.sv
// DEPTH-entry circular buffer with read-through head; push/pop are guarded against overflow/underflow.
module sbox_elastic_buf
   import sbox_pkg::*;
#(
   parameter int unsigned SIZE  = 32,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned CNTW  = f_cntw(DEPTH)
) (
   input  logic            clock,
   input  logic            reset,
   input  logic            push,
   input  logic [SIZE-1:0] push_data,
   input  logic            pop,
   output logic [SIZE-1:0] rd_data,
   output logic            full,
   output logic            empty
);

   localparam int unsigned PTRW = $clog2(DEPTH);

   logic [PTRW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTRW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNTW-1:0] count_q, count_d;
   logic [SIZE-1:0] mem_q [DEPTH];
   logic [SIZE-1:0] mem_d [DEPTH];
   logic            push_ok;
   logic            pop_ok;

   always_comb begin
      full    = (count_q == CNTW'(DEPTH));
      empty   = (count_q == '0);
      push_ok = push && !full;
      pop_ok  = pop && !empty;
      rd_data = mem_q[rd_ptr_q];
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push_ok) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTRW'(1);
      end
      if (pop_ok) begin
         rd_ptr_d = rd_ptr_q + PTRW'(1);
      end
      // Simultaneous push and pop leaves the occupancy unchanged.
      case ({push_ok, pop_ok})
         2'b10:   count_d = count_q + CNTW'(1);
         2'b01:   count_d = count_q - CNTW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Payload storage needs no reset; occupancy alone decides validity.
   always_ff @(posedge clock) begin
      mem_q <= mem_d;
   end

endmodule

// File: rtl/sbox_1xn_buf.sv
// Buffered 1-to-NOUT switch box; a selection change drains buffered tokens to the old channel first.
module sbox_1xn_buf
   import sbox_pkg::*;
#(
   parameter int unsigned SIZE  = 32,
   parameter int unsigned NOUT  = 4,
   parameter int unsigned DEPTH = 2,
   parameter int unsigned SELW  = f_selw(NOUT)
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic [SIZE-1:0]      in1_data,
   input  logic                 in1_write,
   output logic                 in1_full_n,
   output logic [NOUT*SIZE-1:0] out_data,
   output logic [NOUT-1:0]      out_write,
   input  logic [NOUT-1:0]      out_full_n,
   input  logic [SELW-1:0]      sel,
   output logic                 cfg_busy,
   output logic                 sel_err
);

   state_e          state_q, state_d;
   logic [SELW-1:0] active_sel_q, active_sel_d;
   logic [SELW-1:0] pend_sel_q, pend_sel_d;
   logic            sel_err_q, sel_err_d;

   logic            push;
   logic            pop;
   logic            act_full_n;
   logic            sel_valid;
   logic            buf_full;
   logic            buf_empty;
   logic [SIZE-1:0] rd_data;

   sbox_elastic_buf #(
      .SIZE  (SIZE),
      .DEPTH (DEPTH)
   ) u_buf (
      .clock     (clock),
      .reset     (reset),
      .push      (push),
      .push_data (in1_data),
      .pop       (pop),
      .rd_data   (rd_data),
      .full      (buf_full),
      .empty     (buf_empty)
   );

   // Handshake and output demux; everything is held quiet while reset is low.
   always_comb begin
      act_full_n = 1'b0;
      for (int unsigned k = 0; k < NOUT; k++) begin
         if (active_sel_q == SELW'(k)) act_full_n = out_full_n[k];
      end
      in1_full_n = reset && (state_q == RUN) && !buf_full;
      push       = in1_write && in1_full_n;
      pop        = reset && !buf_empty && act_full_n;
      out_write  = '0;
      out_data   = '0;
      for (int unsigned k = 0; k < NOUT; k++) begin
         if (active_sel_q == SELW'(k)) begin
            out_write[k]           = pop;
            out_data[k*SIZE +: SIZE] = buf_empty ? '0 : rd_data;
         end
      end
      cfg_busy = (state_q != RUN);
      sel_err  = sel_err_q;
   end

   // Reconfiguration control: RUN -> DRAIN (until empty) -> SWITCH -> RUN.
   always_comb begin
      state_d      = state_q;
      active_sel_d = active_sel_q;
      pend_sel_d   = pend_sel_q;
      sel_err_d    = sel_err_q;
      sel_valid    = (32'(sel) < NOUT);
      case (state_q)
         RUN: begin
            if (!sel_valid) begin
               sel_err_d = 1'b1;
            end else if (sel != active_sel_q) begin
               pend_sel_d = sel;
               state_d    = DRAIN;
            end
         end
         DRAIN: begin
            if (buf_empty) state_d = SWITCH;
         end
         SWITCH: begin
            active_sel_d = pend_sel_q;
            state_d      = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_q      <= RUN;
         active_sel_q <= '0;
         pend_sel_q   <= '0;
         sel_err_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         active_sel_q <= active_sel_d;
         pend_sel_q   <= pend_sel_d;
         sel_err_q    <= sel_err_d;
      end
   end

endmodule
